// File: rtl/iir_pkg.sv
// Shared IIR sample-width constants and default decimating output stage settings.
// Rounding mode of the output stage is selected with the IIR_OUT_ROUND_EN macro.
package iir_pkg;

   localparam int IIR_IN_W            = 8;
   localparam int IIR_FILT_W          = 13;
   localparam int IIR_DOUT_W          = 8;
   localparam int IIR_DEC_LOG2_DEF    = 2;
   localparam int IIR_OUT_SHIFT_DEF   = 5;
   localparam int IIR_FIFO_DEPTH_DEF  = 4;

endpackage

// File: rtl/iir_sync_fifo.sv
// First-word-fall-through synchronous FIFO with level output; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module iir_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             accept_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             full;
   logic             pop_ok;
   logic             push_ok;

   assign empty_o  = (level_q == '0);
   assign full     = (level_q == LW'(DEPTH));
   assign pop_ok   = pop_i && !empty_o;
   assign push_ok  = push_i && (!full || pop_ok);
   assign accept_o = push_ok;
   assign level_o  = level_q;
   assign rdata_o  = empty_o ? '0 : mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage carries no reset; rdata_o is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/iir_decimating_output_stage.sv
// Block-average decimator, rescale/saturate and output FIFO after the IIR filter.
// Define IIR_OUT_ROUND_EN for round-half-up instead of floor truncation.
module iir_decimating_output_stage
   import iir_pkg::*;
#(
   parameter int DIN_W      = IIR_FILT_W,
   parameter int DOUT_W     = IIR_DOUT_W,
   parameter int DEC_LOG2   = IIR_DEC_LOG2_DEF,
   parameter int OUT_SHIFT  = IIR_OUT_SHIFT_DEF,
   parameter int FIFO_DEPTH = IIR_FIFO_DEPTH_DEF
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic signed [DIN_W-1:0]         din,
   input  logic                            din_valid,
   output logic signed [DOUT_W-1:0]        dout,
   output logic                            dout_valid,
   input  logic                            dout_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            sat_pulse,
   output logic [7:0]                      drop_cnt
);

   localparam int N       = 1 << DEC_LOG2;
   localparam int ACC_W   = DIN_W + DEC_LOG2;
   localparam int QW      = ACC_W + 1;
   localparam int PH_W    = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
   localparam int TS      = DEC_LOG2 + OUT_SHIFT;
   localparam int BIAS_SH = (TS > 0) ? TS - 1 : 0;

   localparam logic signed [QW-1:0] QMAX = QW'((1 << (DOUT_W - 1)) - 1);
   localparam logic signed [QW-1:0] QMIN = ~QMAX;
   localparam logic signed [QW-1:0] BIAS = (TS > 0) ? (QW'(1) << BIAS_SH) : '0;

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [PH_W-1:0]          ph_q, ph_d;
   logic                     sat_q, sat_d;
   logic [7:0]               drop_q, drop_d;
   logic signed [QW-1:0]     sum_ext;
   logic signed [QW-1:0]     q_full;
   logic signed [DOUT_W-1:0] result;
   logic                     clamped;
   logic                     block_end;
   logic                     fifo_empty;
   logic                     fifo_accept;

   function automatic logic signed [QW-1:0] shift_round(input logic signed [QW-1:0] s);
`ifdef IIR_OUT_ROUND_EN
      return (s + BIAS) >>> TS;
`else
      return s >>> TS;
`endif
   endfunction

   function automatic logic is_clamped(input logic signed [QW-1:0] q);
      return (q > QMAX) || (q < QMIN);
   endfunction

   function automatic logic signed [DOUT_W-1:0] saturate(input logic signed [QW-1:0] q);
      if (q > QMAX)      return QMAX[DOUT_W-1:0];
      else if (q < QMIN) return QMIN[DOUT_W-1:0];
      else               return q[DOUT_W-1:0];
   endfunction

   // Extra headroom bit keeps the rounding bias from overflowing the sum.
   assign sum_ext   = {{(QW - ACC_W){acc_q[ACC_W-1]}}, acc_q} + {{(QW - DIN_W){din[DIN_W-1]}}, din};
   assign block_end = din_valid && (ph_q == PH_W'(N - 1));
   assign q_full    = shift_round(sum_ext);
   assign clamped   = is_clamped(q_full);
   assign result    = saturate(q_full);

   always_comb begin
      acc_d  = acc_q;
      ph_d   = ph_q;
      sat_d  = block_end && clamped;
      drop_d = drop_q;
      if (din_valid) begin
         if (block_end) begin
            acc_d = '0;
            ph_d  = '0;
         end else begin
            acc_d = sum_ext[ACC_W-1:0];
            ph_d  = ph_q + PH_W'(1);
         end
      end
      if (block_end && !fifo_accept && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q  <= '0;
         ph_q   <= '0;
         sat_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         acc_q  <= acc_d;
         ph_q   <= ph_d;
         sat_q  <= sat_d;
         drop_q <= drop_d;
      end
   end

   iir_sync_fifo #(
      .WIDTH (DOUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push_i   (block_end),
      .wdata_i  (result),
      .pop_i    (dout_ready),
      .rdata_o  (dout),
      .empty_o  (fifo_empty),
      .accept_o (fifo_accept),
      .level_o  (fifo_level)
   );

   assign dout_valid = !fifo_empty;
   assign sat_pulse  = sat_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_iir_decimating_output_stage.sv
// Directed scoreboard bench for iir_decimating_output_stage at default parameters.
module tb_iir_decimating_output_stage;

   localparam int N     = 4;
   localparam int TS    = 7;
   localparam int DEPTH = 4;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic signed [12:0] din = '0;
   logic               din_valid = 1'b0;
   logic signed [7:0]  dout;
   logic               dout_valid;
   logic               dout_ready = 1'b0;
   logic [2:0]         fifo_level;
   logic               sat_pulse;
   logic [7:0]         drop_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   int macc   = 0;
   int mph    = 0;
   int mlevel = 0;
   int mdrop  = 0;
   int msat   = 0;
   logic signed [7:0] exp_q[$];

   always #5 clk = ~clk;

   iir_decimating_output_stage dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .fifo_level (fifo_level),
      .sat_pulse  (sat_pulse),
      .drop_cnt   (drop_cnt)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int model_q(input int sum);
      int q;
`ifdef IIR_OUT_ROUND_EN
      q = (sum + (1 << (TS - 1))) >>> TS;
`else
      q = sum >>> TS;
`endif
      return q;
   endfunction

   // One clock of stimulus: outputs checked at negedge, model advanced at posedge.
   task automatic step(input logic v, input int d, input logic rdy);
      int   sum, q;
      logic pop;
      din        = d[12:0];
      din_valid  = v;
      dout_ready = rdy;
      @(negedge clk);
      chk("dout_valid", dout_valid, (mlevel > 0));
      chk("fifo_level", fifo_level, mlevel);
      if (mlevel == 0) chk("dout_empty", dout, 0);
      pop = (mlevel > 0) && rdy;
      if (mlevel > 0) begin
         if (pop) chk("dout_pop", dout, exp_q.pop_front());
         else     chk("dout_hold", dout, exp_q[0]);
      end
      @(posedge clk);
      msat = 0;
      if (pop) mlevel--;
      if (v) begin
         if (mph == N - 1) begin
            sum = macc + d;
            q = model_q(sum);
            if (q > 127)       begin q = 127;  msat = 1; end
            else if (q < -128) begin q = -128; msat = 1; end
            if ((mlevel < DEPTH)) begin
               exp_q.push_back(q[7:0]);
               mlevel++;
            end else if (mdrop < 255) begin
               mdrop++;
            end
            macc = 0;
            mph  = 0;
         end else begin
            macc += d;
            mph++;
         end
      end
      #1;
      chk("sat_pulse", sat_pulse, msat);
      chk("drop_cnt", drop_cnt, mdrop);
   endtask

   task automatic blk(input int d, input logic rdy);
      for (int i = 0; i < N; i++) step(1'b1, d, rdy);
   endtask

   task automatic idle(input int cycles, input logic rdy);
      for (int i = 0; i < cycles; i++) step(1'b0, 0, rdy);
   endtask

   task automatic do_reset();
      din_valid = 1'b0;
      reset_n   = 1'b0;
      #2;
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_fifo_level", fifo_level, 0);
      chk("rst_dout", dout, 0);
      chk("rst_sat_pulse", sat_pulse, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      macc = 0; mph = 0; mlevel = 0; mdrop = 0; msat = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      chk("rst_hold_level", fifo_level, 0);
      chk("rst_hold_valid", dout_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      do_reset();

      // Basic means, saturation and negative floor/rounding cases.
      blk(100, 1'b1);    idle(2, 1'b1);
      blk(4095, 1'b1);   idle(2, 1'b1);
      blk(-1, 1'b1);     idle(2, 1'b1);
      blk(-4096, 1'b1);  idle(2, 1'b1);

      // Interleaved valid: one result per four valid samples only.
      for (int i = 0; i < 8; i++) step(i % 2 == 0, 64, 1'b1);
      idle(2, 1'b1);

      // Overrun: five blocks into a stalled FIFO, then drain.
      for (int b = 0; b < 5; b++) blk(32, 1'b0);
      chk("full_level", fifo_level, 4);
      chk("full_drop", drop_cnt, 1);
      idle(6, 1'b1);

      // Push coinciding with a pop while full.
      for (int b = 0; b < 4; b++) blk(32, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 20 * i, 1'b0);
      step(1'b1, 4000, 1'b1);
      chk("full_pop_drop", drop_cnt, 1);
      idle(6, 1'b1);

      // Reset mid-block discards the partial sum.
      step(1'b1, 4095, 1'b1);
      step(1'b1, 4095, 1'b1);
      do_reset();
      blk(0, 1'b1);
      idle(3, 1'b1);
      chk("end_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
